// File: rtl/sdr_receive.sv
// sdr_receive: receive-side UDP payload demultiplexer.
// Dispatches the UDP payload byte stream by destination port: general commands
// (discovery / erase), the high-priority packet (run / PTT), and the DUC IQ and
// audio streams. Stream payload bytes are written into their FIFOs. 32-bit
// sequence numbers are tracked per stream, and a watchdog drops run when the
// high-priority packets stop arriving.
module sdr_receive #(
    parameter logic [15:0] PORT_BASE = 16'd1024,
    parameter logic [31:0] WD_CYCLES = 32'd125_000_000
) (
    input  logic        rx_clock,
    input  logic        reset_n,
    input  logic        udp_rx_active,
    input  logic [7:0]  udp_rx_data,
    input  logic [15:0] to_port,
    input  logic        discovery_ACK,
    input  logic        erase_ACK,
    input  logic        tx_fifo_full,
    input  logic        audio_fifo_full,
    output logic        run,
    output logic        PTT,
    output logic        discovery,
    output logic        erase_req,
    output logic [7:0]  tx_fifo_wrdata,
    output logic        tx_fifo_wrreq,
    output logic [7:0]  audio_fifo_wrdata,
    output logic        audio_fifo_wrreq,
    output logic [15:0] seq_err_count,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEQ      = 3'd1,
        S_GENERAL  = 3'd2,
        S_HIGH_PRI = 3'd3,
        S_DUC_IQ   = 3'd4,
        S_AUDIO    = 3'd5,
        S_DISCARD  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        STR_GEN = 2'd0,
        STR_HP  = 2'd1,
        STR_IQ  = 2'd2,
        STR_AUD = 2'd3
    } stream_t;

    // Saturating 16-bit increment for the error counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Saturating 11-bit increment so very long packets never wrap byte_no.
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        logic [10:0] r;
        if (v == 11'h7FF) begin
            r = v;
        end else begin
            r = v + 11'd1;
        end
        return r;
    endfunction

    state_t      state_r;
    stream_t     stream_r;
    logic [10:0] byte_no_r;        // index of the byte on the bus this cycle
    logic [23:0] seq_r;            // sequence bytes 0..2, MSB first
    logic        prev_active_r;    // reset high so a packet in flight at reset is ignored
    logic [1:0]  hp_shadow_r;      // high-priority byte 4, bits [1:0]
    logic [31:0] exp_hp_r;
    logic [31:0] exp_iq_r;
    logic [31:0] exp_aud_r;
    logic        sync_hp_r;
    logic        sync_iq_r;
    logic        sync_aud_r;
    logic [31:0] wd_r;
    logic        run_d_r;

    logic        port_known_s;
    stream_t     port_stream_s;
    state_t      stream_state_s;
    logic [31:0] seq_full_s;
    logic [31:0] exp_sel_s;
    logic        sync_sel_s;
    logic        gen_byte4_s;
    logic        disc_set_s;
    logic        erase_set_s;
    logic        hp_done_s;
    logic        run_fall_s;

    // Map the destination port onto a stream.
    always_comb begin
        port_known_s  = 1'b1;
        port_stream_s = STR_GEN;
        if (to_port == PORT_BASE) begin
            port_stream_s = STR_GEN;
        end else if (to_port == PORT_BASE + 16'd3) begin
            port_stream_s = STR_HP;
        end else if (to_port == PORT_BASE + 16'd4) begin
            port_stream_s = STR_IQ;
        end else if (to_port == PORT_BASE + 16'd5) begin
            port_stream_s = STR_AUD;
        end else begin
            port_known_s = 1'b0;
        end
    end

    // Select the payload state and the per-stream sequence tracking for the latched stream.
    always_comb begin
        stream_state_s = S_DISCARD;
        exp_sel_s      = 32'd0;
        sync_sel_s     = 1'b0;
        case (stream_r)
            STR_GEN: begin
                stream_state_s = S_GENERAL;
            end
            STR_HP: begin
                stream_state_s = S_HIGH_PRI;
                exp_sel_s      = exp_hp_r;
                sync_sel_s     = sync_hp_r;
            end
            STR_IQ: begin
                stream_state_s = S_DUC_IQ;
                exp_sel_s      = exp_iq_r;
                sync_sel_s     = sync_iq_r;
            end
            STR_AUD: begin
                stream_state_s = S_AUDIO;
                exp_sel_s      = exp_aud_r;
                sync_sel_s     = sync_aud_r;
            end
            default: begin
                stream_state_s = S_DISCARD;
            end
        endcase
    end

    // Decode command bytes, packet completion and run falling.
    always_comb begin
        seq_full_s  = {seq_r, udp_rx_data};
        gen_byte4_s = (state_r == S_GENERAL) && udp_rx_active && (byte_no_r == 11'd4);
        disc_set_s  = gen_byte4_s && (udp_rx_data == 8'h02);
        erase_set_s = gen_byte4_s && (udp_rx_data == 8'h03);
        hp_done_s   = (state_r == S_HIGH_PRI) && !udp_rx_active && (byte_no_r > 11'd4);
        run_fall_s  = run_d_r && !run;
    end

    // Packet FSM: parsing, sequence checking, command levels and FIFO writes.
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= S_IDLE;
            stream_r          <= STR_GEN;
            byte_no_r         <= 11'd0;
            seq_r             <= 24'd0;
            prev_active_r     <= 1'b1;
            hp_shadow_r       <= 2'd0;
            exp_hp_r          <= 32'd0;
            exp_iq_r          <= 32'd0;
            exp_aud_r         <= 32'd0;
            sync_hp_r         <= 1'b0;
            sync_iq_r         <= 1'b0;
            sync_aud_r        <= 1'b0;
            discovery         <= 1'b0;
            erase_req         <= 1'b0;
            tx_fifo_wrdata    <= 8'd0;
            tx_fifo_wrreq     <= 1'b0;
            audio_fifo_wrdata <= 8'd0;
            audio_fifo_wrreq  <= 1'b0;
            seq_err_count     <= 16'd0;
            overrun           <= 1'b0;
        end else begin
            prev_active_r    <= udp_rx_active;
            tx_fifo_wrreq    <= 1'b0;
            audio_fifo_wrreq <= 1'b0;

            if (discovery && discovery_ACK) begin
                discovery <= 1'b0;
            end else if (disc_set_s) begin
                discovery <= 1'b1;
            end else begin
                discovery <= discovery;
            end

            if (erase_req && erase_ACK) begin
                erase_req <= 1'b0;
            end else if (erase_set_s) begin
                erase_req <= 1'b1;
            end else begin
                erase_req <= erase_req;
            end

            case (state_r)
                S_IDLE: begin
                    if (udp_rx_active && !prev_active_r) begin
                        seq_r     <= {16'd0, udp_rx_data};
                        byte_no_r <= 11'd1;
                        stream_r  <= port_stream_s;
                        if (port_known_s) begin
                            state_r <= S_SEQ;
                        end else begin
                            state_r <= S_DISCARD;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SEQ: begin
                    if (!udp_rx_active) begin
                        state_r <= S_IDLE;
                    end else begin
                        seq_r     <= {seq_r[15:0], udp_rx_data};
                        byte_no_r <= sat_inc11(byte_no_r);
                        if (byte_no_r == 11'd3) begin
                            state_r <= stream_state_s;
                            if ((stream_r != STR_GEN) && sync_sel_s && (seq_full_s != exp_sel_s)) begin
                                seq_err_count <= sat_inc16(seq_err_count);
                            end
                            case (stream_r)
                                STR_HP: begin
                                    exp_hp_r  <= seq_full_s + 32'd1;
                                    sync_hp_r <= 1'b1;
                                end
                                STR_IQ: begin
                                    exp_iq_r  <= seq_full_s + 32'd1;
                                    sync_iq_r <= 1'b1;
                                end
                                STR_AUD: begin
                                    exp_aud_r  <= seq_full_s + 32'd1;
                                    sync_aud_r <= 1'b1;
                                end
                                default: begin
                                    exp_hp_r <= exp_hp_r;
                                end
                            endcase
                        end
                    end
                end
                S_GENERAL, S_DISCARD: begin
                    if (!udp_rx_active) begin
                        state_r <= S_IDLE;
                    end else begin
                        byte_no_r <= sat_inc11(byte_no_r);
                    end
                end
                S_HIGH_PRI: begin
                    if (!udp_rx_active) begin
                        state_r <= S_IDLE;
                    end else begin
                        byte_no_r <= sat_inc11(byte_no_r);
                        if (byte_no_r == 11'd4) begin
                            hp_shadow_r <= udp_rx_data[1:0];
                        end
                    end
                end
                S_DUC_IQ: begin
                    if (!udp_rx_active) begin
                        state_r <= S_IDLE;
                    end else begin
                        byte_no_r <= sat_inc11(byte_no_r);
                        if (byte_no_r >= 11'd4) begin
                            if (tx_fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                tx_fifo_wrdata <= udp_rx_data;
                                tx_fifo_wrreq  <= 1'b1;
                            end
                        end
                    end
                end
                S_AUDIO: begin
                    if (!udp_rx_active) begin
                        state_r <= S_IDLE;
                    end else begin
                        byte_no_r <= sat_inc11(byte_no_r);
                        if (byte_no_r >= 11'd4) begin
                            if (audio_fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                audio_fifo_wrdata <= udp_rx_data;
                                audio_fifo_wrreq  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase

            // Losing run desynchronises every stream so the next sequence is accepted.
            if (run_fall_s) begin
                sync_hp_r  <= 1'b0;
                sync_iq_r  <= 1'b0;
                sync_aud_r <= 1'b0;
            end
        end
    end

    // run/PTT update from completed high-priority packets and the run watchdog.
    always_ff @(posedge rx_clock or negedge reset_n) begin
        if (!reset_n) begin
            run     <= 1'b0;
            PTT     <= 1'b0;
            wd_r    <= 32'd0;
            run_d_r <= 1'b0;
        end else begin
            run_d_r <= run;
            if (hp_done_s) begin
                run  <= hp_shadow_r[0];
                PTT  <= hp_shadow_r[1];
                wd_r <= 32'd0;
            end else if (run) begin
                if (wd_r >= WD_CYCLES - 32'd1) begin
                    run  <= 1'b0;
                    PTT  <= 1'b0;
                    wd_r <= 32'd0;
                end else begin
                    wd_r <= wd_r + 32'd1;
                end
            end else begin
                wd_r <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_sdr_receive.sv
// Scoreboard bench for sdr_receive: stimulus pushes expected FIFO bytes into
// queues, and a negedge monitor pops and compares every write strobe.
module tb_sdr_receive;

    logic        rx_clock = 1'b0;
    logic        reset_n;
    logic        udp_rx_active;
    logic [7:0]  udp_rx_data;
    logic [15:0] to_port;
    logic        discovery_ACK;
    logic        erase_ACK;
    logic        tx_fifo_full;
    logic        audio_fifo_full;
    logic        run;
    logic        PTT;
    logic        discovery;
    logic        erase_req;
    logic [7:0]  tx_fifo_wrdata;
    logic        tx_fifo_wrreq;
    logic [7:0]  audio_fifo_wrdata;
    logic        audio_fifo_wrreq;
    logic [15:0] seq_err_count;
    logic        overrun;

    sdr_receive #(
        .PORT_BASE(16'd1024),
        .WD_CYCLES(32'd1000)
    ) dut (
        .rx_clock          (rx_clock),
        .reset_n           (reset_n),
        .udp_rx_active     (udp_rx_active),
        .udp_rx_data       (udp_rx_data),
        .to_port           (to_port),
        .discovery_ACK     (discovery_ACK),
        .erase_ACK         (erase_ACK),
        .tx_fifo_full      (tx_fifo_full),
        .audio_fifo_full   (audio_fifo_full),
        .run               (run),
        .PTT               (PTT),
        .discovery         (discovery),
        .erase_req         (erase_req),
        .tx_fifo_wrdata    (tx_fifo_wrdata),
        .tx_fifo_wrreq     (tx_fifo_wrreq),
        .audio_fifo_wrdata (audio_fifo_wrdata),
        .audio_fifo_wrreq  (audio_fifo_wrreq),
        .seq_err_count     (seq_err_count),
        .overrun           (overrun)
    );

    always #5 rx_clock = ~rx_clock;

    int tests = 0;
    int fails = 0;
    int iq_cnt = 0;
    int aud_cnt = 0;
    logic [7:0] iq_q[$];
    logic [7:0] aud_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int i, input logic [7:0] s);
        logic [7:0] v;
        v = 8'(i) + s;
        return v;
    endfunction

    // Monitor: every write strobe must match the next queued byte.
    always @(negedge rx_clock) begin
        if (reset_n && tx_fifo_wrreq) begin
            iq_cnt++;
            if (iq_q.size() == 0) begin
                check("iq_unexpected_write", 32'd1, 32'd0);
            end else begin
                check("iq_data", {24'd0, tx_fifo_wrdata}, {24'd0, iq_q.pop_front()});
            end
        end
        if (reset_n && audio_fifo_wrreq) begin
            aud_cnt++;
            if (aud_q.size() == 0) begin
                check("aud_unexpected_write", 32'd1, 32'd0);
            end else begin
                check("aud_data", {24'd0, audio_fifo_wrdata}, {24'd0, aud_q.pop_front()});
            end
        end
    end

    task automatic send_pkt(input logic [15:0] port, input logic [31:0] seq, input int len,
                            input logic [7:0] b4, input int full_from, input int full_to);
        logic full;
        for (int i = 0; i < len; i++) begin
            @(negedge rx_clock);
            udp_rx_active = 1'b1;
            to_port       = port;
            if (i < 4) begin
                udp_rx_data = seq[31-8*i -: 8];
            end else if (i == 4) begin
                udp_rx_data = b4;
            end else begin
                udp_rx_data = pay(i, seq[7:0]);
            end
            full = (i >= full_from) && (i <= full_to);
            tx_fifo_full    = (port == 16'd1028) ? full : 1'b0;
            audio_fifo_full = (port == 16'd1029) ? full : 1'b0;
            if (i >= 4 && !full && port == 16'd1028) iq_q.push_back(udp_rx_data);
            if (i >= 4 && !full && port == 16'd1029) aud_q.push_back(udp_rx_data);
        end
        @(negedge rx_clock);
        udp_rx_active   = 1'b0;
        udp_rx_data     = 8'd0;
        tx_fifo_full    = 1'b0;
        audio_fifo_full = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        udp_rx_active = 1'b0;
        udp_rx_data = 8'd0;
        to_port = 16'd0;
        discovery_ACK = 1'b0;
        erase_ACK = 1'b0;
        tx_fifo_full = 1'b0;
        audio_fifo_full = 1'b0;
        repeat (3) @(negedge rx_clock);
        check("reset_outputs", {9'd0, run, PTT, discovery, erase_req, tx_fifo_wrreq,
              audio_fifo_wrreq, overrun, seq_err_count}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge rx_clock);

        // General: discovery request and acknowledge
        send_pkt(16'd1024, 32'd0, 5, 8'h02, -1, -1);
        @(negedge rx_clock);
        check("disc_set", {31'd0, discovery}, 32'd1);
        check("disc_run_unchanged", {31'd0, run}, 32'd0);
        repeat (3) @(negedge rx_clock);
        check("disc_hold", {31'd0, discovery}, 32'd1);
        discovery_ACK = 1'b1;
        @(negedge rx_clock);
        discovery_ACK = 1'b0;
        check("disc_clear", {31'd0, discovery}, 32'd0);

        // General: erase request and acknowledge
        send_pkt(16'd1024, 32'd1, 5, 8'h03, -1, -1);
        @(negedge rx_clock);
        check("erase_set", {30'd0, erase_req, discovery}, 32'd2);
        erase_ACK = 1'b1;
        @(negedge rx_clock);
        erase_ACK = 1'b0;
        check("erase_clear", {31'd0, erase_req}, 32'd0);

        // General: unknown command, and an unknown port, change nothing
        send_pkt(16'd1024, 32'd2, 5, 8'h07, -1, -1);
        send_pkt(16'd2000, 32'd0, 10, 8'h02, -1, -1);
        @(negedge rx_clock);
        check("gen_ignored", {30'd0, discovery, erase_req}, 32'd0);

        // High priority: run/PTT, short packet no-op, PTT drop
        send_pkt(16'd1027, 32'd0, 8, 8'h03, -1, -1);
        @(negedge rx_clock);
        check("hp_run_ptt", {30'd0, run, PTT}, 32'd3);
        send_pkt(16'd1027, 32'd1, 4, 8'h00, -1, -1);
        @(negedge rx_clock);
        check("hp_short_nochange", {30'd0, run, PTT}, 32'd3);
        send_pkt(16'd1027, 32'd2, 5, 8'h01, -1, -1);
        @(negedge rx_clock);
        check("hp_ptt_off", {30'd0, run, PTT}, 32'd2);

        // Watchdog: run falls exactly WD_CYCLES cycles after the last packet
        send_pkt(16'd1027, 32'd3, 5, 8'h03, -1, -1);
        repeat (1000) @(negedge rx_clock);
        check("wd_before", {30'd0, run, PTT}, 32'd3);
        @(negedge rx_clock);
        check("wd_fire", {30'd0, run, PTT}, 32'd0);
        check("hp_seq_ok", {16'd0, seq_err_count}, 32'd0);

        // DUC IQ: seq 5 then seq 7 (one mismatch)
        iq_cnt = 0;
        send_pkt(16'd1028, 32'd5, 1444, 8'h5A, -1, -1);
        repeat (3) @(negedge rx_clock);
        check("iq_count_1", iq_cnt, 32'd1440);
        check("iq_seq_first", {16'd0, seq_err_count}, 32'd0);
        iq_cnt = 0;
        send_pkt(16'd1028, 32'd7, 1444, 8'hC3, -1, -1);
        repeat (3) @(negedge rx_clock);
        check("iq_count_2", iq_cnt, 32'd1440);
        check("iq_seq_err", {16'd0, seq_err_count}, 32'd1);
        check("iq_queue_empty", iq_q.size(), 32'd0);

        // Audio stream, first packet accepted
        aud_cnt = 0;
        send_pkt(16'd1029, 32'h0000_1234, 20, 8'hAA, -1, -1);
        repeat (3) @(negedge rx_clock);
        check("aud_count", aud_cnt, 32'd16);
        check("aud_seq", {16'd0, seq_err_count}, 32'd1);
        check("overrun_clear", {31'd0, overrun}, 32'd0);

        // DUC IQ with FIFO full for bytes 100..109
        iq_cnt = 0;
        send_pkt(16'd1028, 32'd8, 1444, 8'h11, 100, 109);
        repeat (3) @(negedge rx_clock);
        check("iq_full_count", iq_cnt, 32'd1430);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("iq_full_seq", {16'd0, seq_err_count}, 32'd1);
        repeat (5) @(negedge rx_clock);
        check("overrun_held", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a DUC packet
        iq_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge rx_clock);
            udp_rx_active = 1'b1;
            to_port = 16'd1028;
            udp_rx_data = (i < 4) ? ((i == 3) ? 8'd9 : 8'd0) : pay(i, 8'h40);
            if (i >= 4) iq_q.push_back(udp_rx_data);
        end
        @(negedge rx_clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", {9'd0, run, PTT, discovery, erase_req, tx_fifo_wrreq,
              audio_fifo_wrreq, overrun, seq_err_count}, 32'd0);
        check("reset_pre_count", iq_cnt, 32'd16);
        for (int i = 21; i < 40; i++) begin
            @(negedge rx_clock);
            if (i == 25) reset_n = 1'b1;
            udp_rx_data = pay(i, 8'h40);
        end
        @(negedge rx_clock);
        udp_rx_active = 1'b0;
        repeat (3) @(negedge rx_clock);
        check("reset_no_write", iq_cnt, 32'd16);
        send_pkt(16'd1028, 32'd100, 10, 8'h77, -1, -1);
        repeat (3) @(negedge rx_clock);
        check("post_reset_count", iq_cnt, 32'd22);
        check("post_reset_seq", {16'd0, seq_err_count}, 32'd0);
        check("final_queue_empty", iq_q.size() + aud_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
